// File: rtl/ysyx_22040632_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the memory arbiter and the memory bridge.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface ysyx_22040632_mem_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic            if_req_valid;
  logic            if_req_ready;
  logic [AW-1:0]   if_addr;
  logic            if_rsp_valid;
  logic [DW-1:0]   if_rdata;
  logic            if_rsp_err;

  logic            ls_req_valid;
  logic            ls_req_ready;
  logic [AW-1:0]   ls_addr;
  logic            ls_wen;
  logic [DW-1:0]   ls_wdata;
  logic [DW/8-1:0] ls_wmask;
  logic            ls_rsp_valid;
  logic [DW-1:0]   ls_rdata;
  logic            ls_rsp_err;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_addr;
  logic            mem_wen;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rdata;
  logic            mem_rsp_err;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rdata, if_rsp_err,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output ls_req_ready, ls_rsp_valid, ls_rdata, ls_rsp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rdata, if_rsp_err,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  ls_req_ready, ls_rsp_valid, ls_rdata, ls_rsp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err
  );
endinterface

// File: rtl/ysyx_22040632_mem_arbiter.sv
// Shares one memory port between IFU and LSU with a single transaction in flight.
// Define MEMARB_TIMEOUT_EN to add a watchdog that ends a stuck access with an error.
module ysyx_22040632_mem_arbiter #(
  parameter int AW        = 64,
  parameter int DW        = 64,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22040632_mem_arbiter_if.slave bus,
  output logic                       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  logic   owner_ls;
  logic   last_ls;

  logic          grant_if;
  logic          grant_ls;
  logic          tmo_hit;
  logic          rsp_fire;
  logic          rsp_err;
  logic [DW-1:0] rsp_data;

  logic            vld_p0;
  logic [AW-1:0]   addr_p0;
  logic            wen_p0;
  logic [DW-1:0]   wdata_p0;
  logic [DW/8-1:0] wmask_p0;

  logic            if_vld_p1;
  logic [DW-1:0]   if_rdata_p1;
  logic            if_err_p1;
  logic            ls_vld_p1;
  logic [DW-1:0]   ls_rdata_p1;
  logic            ls_err_p1;

  // Grant is only offered while idle; on a tie the last grantee yields unless LSU is fixed-priority.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state == S_IDLE && !rst) begin
      if (bus.if_req_valid && bus.ls_req_valid) begin
        if (PRIO_MODE == 1 || !last_ls) grant_ls = 1'b1;
        else                            grant_if = 1'b1;
      end else begin
        grant_if = bus.if_req_valid;
        grant_ls = bus.ls_req_valid;
      end
    end
  end

  assign bus.if_req_ready = grant_if;
  assign bus.ls_req_ready = grant_ls;

`ifdef MEMARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wdog_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                     wdog_cnt <= '0;
    else if (state == S_REQ || state == S_WAIT)  wdog_cnt <= wdog_cnt + 1'b1;
    else                                         wdog_cnt <= '0;
  end

  assign tmo_hit = (state == S_REQ || state == S_WAIT) && (wdog_cnt == CNT_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // A real response in WAIT beats a watchdog expiry in the same cycle.
  always_comb begin
    rsp_fire = 1'b0;
    rsp_data = '0;
    rsp_err  = 1'b0;
    if (state == S_WAIT && bus.mem_rsp_valid) begin
      rsp_fire = 1'b1;
      rsp_data = bus.mem_rdata;
      rsp_err  = bus.mem_rsp_err;
    end else if (tmo_hit) begin
      rsp_fire = 1'b1;
      rsp_err  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner_ls    <= 1'b0;
      last_ls     <= 1'b1;
      vld_p0      <= 1'b0;
      addr_p0     <= '0;
      wen_p0      <= 1'b0;
      wdata_p0    <= '0;
      wmask_p0    <= '0;
      if_vld_p1   <= 1'b0;
      if_rdata_p1 <= '0;
      if_err_p1   <= 1'b0;
      ls_vld_p1   <= 1'b0;
      ls_rdata_p1 <= '0;
      ls_err_p1   <= 1'b0;
    end else begin
      if_vld_p1   <= 1'b0;
      if_rdata_p1 <= '0;
      if_err_p1   <= 1'b0;
      ls_vld_p1   <= 1'b0;
      ls_rdata_p1 <= '0;
      ls_err_p1   <= 1'b0;

      if (rsp_fire) begin
        // response stage: route captured data to the owner only
        state  <= S_RESP;
        vld_p0 <= 1'b0;
        if (owner_ls) begin
          ls_vld_p1   <= 1'b1;
          ls_rdata_p1 <= rsp_data;
          ls_err_p1   <= rsp_err;
        end else begin
          if_vld_p1   <= 1'b1;
          if_rdata_p1 <= rsp_data;
          if_err_p1   <= rsp_err;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (grant_if || grant_ls) begin
              // request stage: capture winner's fields; fetches never write
              state    <= S_REQ;
              owner_ls <= grant_ls;
              last_ls  <= grant_ls;
              vld_p0   <= 1'b1;
              addr_p0  <= grant_ls ? bus.ls_addr : bus.if_addr;
              wen_p0   <= grant_ls & bus.ls_wen;
              wdata_p0 <= grant_ls ? bus.ls_wdata : '0;
              wmask_p0 <= grant_ls ? bus.ls_wmask : '0;
            end
          end
          S_REQ: begin
            if (bus.mem_req_ready) begin
              state  <= S_WAIT;
              vld_p0 <= 1'b0;
            end
          end
          S_RESP:  state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  // Valid is withdrawn combinationally in the expiry cycle so no late handshake slips through.
  assign bus.mem_req_valid = vld_p0 & ~tmo_hit;
  assign bus.mem_addr      = addr_p0;
  assign bus.mem_wen       = wen_p0;
  assign bus.mem_wdata     = wdata_p0;
  assign bus.mem_wmask     = wmask_p0;

  assign bus.if_rsp_valid  = if_vld_p1;
  assign bus.if_rdata      = if_rdata_p1;
  assign bus.if_rsp_err    = if_err_p1;
  assign bus.ls_rsp_valid  = ls_vld_p1;
  assign bus.ls_rdata      = ls_rdata_p1;
  assign bus.ls_rsp_err    = ls_err_p1;

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ysyx_22040632_mem_arbiter.sv
// Self-checking bench for ysyx_22040632_mem_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model. Honours MEMARB_TIMEOUT_EN.
module tb_ysyx_22040632_mem_arbiter;

`ifdef MEMARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic clk;
  logic rst;
  logic busy0;
  logic busy1;

  ysyx_22040632_mem_arbiter_if #(.AW(64), .DW(64)) b0 ();
  ysyx_22040632_mem_arbiter_if #(.AW(64), .DW(64)) b1 ();

  ysyx_22040632_mem_arbiter #(.AW(64), .DW(64), .PRIO_MODE(0), .TIMEOUT(TMO)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0),
    .busy(busy0)
  );

  ysyx_22040632_mem_arbiter #(.AW(64), .DW(64), .PRIO_MODE(1), .TIMEOUT(TMO)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1),
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // drive values for dut0, applied by step()
  bit          d_iv, d_lv, d_lw, d_mr, d_mv, d_me;
  logic [63:0] d_ia, d_la, d_ld, d_md;
  logic [7:0]  d_lm;
  bit          o_if_rdy, o_ls_rdy;

  // reference model: at most one transaction, tracked as a record plus progress flags
  bit          m_active, m_issued, m_rsp, m_own_ls, m_last_ls;
  logic [63:0] m_addr, m_wdata, m_rdata;
  bit          m_wen, m_err;
  logic [7:0]  m_wmask;
  int          m_age;

  task automatic model_reset();
    m_active = 0; m_issued = 0; m_rsp = 0; m_own_ls = 0; m_last_ls = 1;
    m_age = 0;
  endtask

  task automatic clear_drv();
    d_iv = 0; d_lv = 0; d_lw = 0; d_mr = 0; d_mv = 0; d_me = 0;
    d_ia = '0; d_la = '0; d_ld = '0; d_md = '0; d_lm = '0;
  endtask

  task automatic step(input bit r);
    bit gi, gl, to, exp_mv, ifr, lsr;
    @(negedge clk);
    rst              = r;
    b0.if_req_valid  = d_iv;
    b0.if_addr       = d_ia;
    b0.ls_req_valid  = d_lv;
    b0.ls_addr       = d_la;
    b0.ls_wen        = d_lw;
    b0.ls_wdata      = d_ld;
    b0.ls_wmask      = d_lm;
    b0.mem_req_ready = d_mr;
    b0.mem_rsp_valid = d_mv;
    b0.mem_rdata     = d_md;
    b0.mem_rsp_err   = d_me;
    #1;
    to = 0;
`ifdef MEMARB_TIMEOUT_EN
    to = m_active && !m_rsp && (m_age == TMO - 1) && !(m_issued && d_mv);
`endif
    gi = 0; gl = 0;
    if (!m_active && !r) begin
      if (d_iv && d_lv) begin
        if (m_last_ls) gi = 1;
        else           gl = 1;
      end else begin
        gi = d_iv;
        gl = d_lv;
      end
    end
    exp_mv = m_active && !m_issued && !m_rsp && !to;
    ifr = m_rsp && !m_own_ls;
    lsr = m_rsp && m_own_ls;
    check("if_req_ready", b0.if_req_ready, gi);
    check("ls_req_ready", b0.ls_req_ready, gl);
    check("busy", busy0, m_active);
    check("mem_req_valid", b0.mem_req_valid, exp_mv);
    if (exp_mv) begin
      check("mem_addr", b0.mem_addr, m_addr);
      check("mem_wen", b0.mem_wen, m_wen);
      check("mem_wdata", b0.mem_wdata, m_wdata);
      check("mem_wmask", b0.mem_wmask, m_wmask);
    end
    check("if_rsp_valid", b0.if_rsp_valid, ifr);
    check("if_rdata", b0.if_rdata, ifr ? m_rdata : 64'h0);
    check("if_rsp_err", b0.if_rsp_err, ifr ? m_err : 1'b0);
    check("ls_rsp_valid", b0.ls_rsp_valid, lsr);
    check("ls_rdata", b0.ls_rdata, lsr ? m_rdata : 64'h0);
    check("ls_rsp_err", b0.ls_rsp_err, lsr ? m_err : 1'b0);
    o_if_rdy = b0.if_req_ready;
    o_ls_rdy = b0.ls_req_ready;
    // advance the model across the coming clock edge
    if (r) begin
      model_reset();
    end else if (m_rsp) begin
      m_active = 0;
      m_rsp    = 0;
    end else if (m_active) begin
      if (to) begin
        m_rsp = 1; m_rdata = '0; m_err = 1;
      end else if (!m_issued) begin
        if (d_mr) m_issued = 1;
      end else if (d_mv) begin
        m_rsp = 1; m_rdata = d_md; m_err = d_me;
      end
      m_age++;
    end else if (gi || gl) begin
      m_active  = 1;
      m_issued  = 0;
      m_age     = 0;
      m_own_ls  = gl;
      m_last_ls = gl;
      m_addr    = gl ? d_la : d_ia;
      m_wen     = gl && d_lw;
      m_wdata   = gl ? d_ld : 64'h0;
      m_wmask   = gl ? d_lm : 8'h0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int          n_g, n_r, k;
    bit          rsp_nxt, ip, lp, was, waiting, r;
    int          dly;
    int          gseq[$];
    logic [63:0] ia, la, ld;
    bit          lw;
    logic [7:0]  lm;

    rst = 1;
    clear_drv();
    b1.if_req_valid = 0; b1.if_addr = '0; b1.ls_req_valid = 0; b1.ls_addr = '0;
    b1.ls_wen = 0; b1.ls_wdata = '0; b1.ls_wmask = '0; b1.mem_req_ready = 0;
    b1.mem_rsp_valid = 0; b1.mem_rdata = '0; b1.mem_rsp_err = 0;
    model_reset();
    repeat (3) @(posedge clk);

    // reset state
    step(1);
    check("rst_mem_addr", b0.mem_addr, 64'h0);
    check("rst_mem_wdata", b0.mem_wdata, 64'h0);
    check("rst_mem_wmask", b0.mem_wmask, 8'h0);
    check("rst_mem_wen", b0.mem_wen, 1'b0);
    check("rst_busy1", busy1, 1'b0);

    // PRIO_MODE=1 instance: both requesting continuously, LSU must always win
    b1.if_req_valid = 1; b1.if_addr = 64'h8000_0000;
    b1.ls_req_valid = 1; b1.ls_addr = 64'h8000_3000;
    b1.mem_req_ready = 1;
    n_g = 0; n_r = 0; rsp_nxt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst = 0;
      b1.mem_rsp_valid = rsp_nxt;
      b1.mem_rdata     = 64'(i);
      #1;
      check("p1_if_req_ready", b1.if_req_ready, 1'b0);
      check("p1_if_rsp_valid", b1.if_rsp_valid, 1'b0);
      if (b1.ls_req_ready) n_g++;
      if (b1.ls_rsp_valid) n_r++;
      rsp_nxt = b1.mem_req_valid && b1.mem_req_ready;
    end
    check("p1_ls_grants", n_g, 4);
    check("p1_ls_rsps", n_r, 4);
    @(negedge clk);
    b1.if_req_valid = 0; b1.ls_req_valid = 0; b1.mem_rsp_valid = 0; b1.mem_req_ready = 0;

    // IF-only minimum-latency fetch
    clear_drv(); d_iv = 1; d_ia = 64'h8000_0000;
    step(0);
    check("ifo_ready_t", b0.if_req_ready, 1'b1);
    check("ifo_busy_t", busy0, 1'b0);
    clear_drv(); d_mr = 1;
    step(0);
    check("ifo_mem_valid_t1", b0.mem_req_valid, 1'b1);
    check("ifo_mem_addr_t1", b0.mem_addr, 64'h8000_0000);
    check("ifo_busy_t1", busy0, 1'b1);
    clear_drv(); d_mv = 1; d_md = 64'h0000_0413;
    step(0);
    check("ifo_busy_t2", busy0, 1'b1);
    clear_drv();
    step(0);
    check("ifo_rsp_t3", b0.if_rsp_valid, 1'b1);
    check("ifo_rdata_t3", b0.if_rdata, 64'h413);
    check("ifo_err_t3", b0.if_rsp_err, 1'b0);
    check("ifo_busy_t3", busy0, 1'b1);
    step(0);
    check("ifo_busy_t4", busy0, 1'b0);

    // tie with round-robin: IF, LS, IF from reset; stray responses sprinkled everywhere
    clear_drv();
    step(1);
    gseq.delete();
    for (int i = 0; i < 12; i++) begin
      clear_drv();
      d_iv = 1; d_ia = 64'h8000_0100;
      d_lv = 1; d_la = 64'h8000_2000;
      d_mr = 1; d_mv = 1; d_md = 64'h1000 + 64'(i); d_me = i[0];
      step(0);
      if (o_if_rdy) gseq.push_back(0);
      if (o_ls_rdy) gseq.push_back(1);
    end
    check("tie0_grant_count", gseq.size(), 3);
    if (gseq.size() == 3) begin
      check("tie0_grant0_if", gseq[0], 0);
      check("tie0_grant1_ls", gseq[1], 1);
      check("tie0_grant2_if", gseq[2], 0);
    end

    // store held stable under back-pressure
    clear_drv(); d_lv = 1; d_la = 64'h8000_1000; d_lw = 1; d_ld = 64'hdead_beef; d_lm = 8'h0f;
    step(0);
    check("st_ready", b0.ls_req_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      clear_drv();
      step(0);
      check("st_hold_valid", b0.mem_req_valid, 1'b1);
      check("st_hold_addr", b0.mem_addr, 64'h8000_1000);
      check("st_hold_wen", b0.mem_wen, 1'b1);
      check("st_hold_wdata", b0.mem_wdata, 64'hdead_beef);
      check("st_hold_wmask", b0.mem_wmask, 8'h0f);
    end
    clear_drv(); d_mr = 1;
    step(0);
    clear_drv(); d_mv = 1; d_md = 64'h55;
    step(0);
    clear_drv();
    step(0);
    check("st_ls_rsp", b0.ls_rsp_valid, 1'b1);
    check("st_if_rsp", b0.if_rsp_valid, 1'b0);
    step(0);

    // reset while waiting for memory
    clear_drv(); d_iv = 1; d_ia = 64'h8000_0040;
    step(0);
    clear_drv(); d_mr = 1;
    step(0);
    clear_drv();
    step(1);
    clear_drv(); d_mv = 1; d_md = 64'hbad;
    step(0);
    check("rw_busy_after_rst", busy0, 1'b0);
    clear_drv();
    step(0);
    check("rw_no_if_rsp", b0.if_rsp_valid, 1'b0);
    check("rw_no_ls_rsp", b0.ls_rsp_valid, 1'b0);
    clear_drv(); d_iv = 1; d_ia = 64'h8000_0080;
    step(0);
    check("rw_regrant", b0.if_req_ready, 1'b1);
    clear_drv(); d_mr = 1;
    step(0);
    clear_drv(); d_mv = 1; d_md = 64'h1234;
    step(0);
    clear_drv();
    step(0);
    check("rw_rsp", b0.if_rsp_valid, 1'b1);
    check("rw_rdata", b0.if_rdata, 64'h1234);

`ifdef MEMARB_TIMEOUT_EN
    // memory accepts but never answers
    clear_drv(); d_lv = 1; d_la = 64'h8000_4000;
    step(0);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      clear_drv(); d_mr = 1;
      step(0);
      if (b0.ls_rsp_valid) begin
        k = i;
        break;
      end
    end
    check("tmo_latency", k, 17);
    check("tmo_err", b0.ls_rsp_err, 1'b1);
    check("tmo_rdata", b0.ls_rdata, 64'h0);
    clear_drv();
    step(0);
`endif

    // random traffic against the model
    ip = 0; lp = 0; dly = 0;
    ia = '0; la = '0; ld = '0; lw = 0; lm = '0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 299) == 0);
      if (!ip) begin
        ia = {32'h8000_0000, $urandom};
        ip = ($urandom_range(0, 1) == 1);
      end
      if (!lp) begin
        la = {32'h8000_0000, $urandom};
        ld = {$urandom, $urandom};
        lw = $urandom_range(0, 1) == 1;
        lm = 8'($urandom);
        lp = ($urandom_range(0, 2) != 0);
      end
      d_iv = ip; d_ia = ia;
      d_lv = lp; d_la = la; d_lw = lw; d_ld = ld; d_lm = lm;
      d_mr = ($urandom_range(0, 9) < 7);
      waiting = m_active && m_issued && !m_rsp;
      d_mv = 0;
      if (waiting) begin
        if (dly == 0) d_mv = 1;
        else          dly--;
      end else begin
        d_mv = ($urandom_range(0, 7) == 0);
      end
      d_md = {$urandom, $urandom};
      d_me = ($urandom_range(0, 7) == 0);
      was  = m_issued;
      step(r);
      if (!was && m_issued) dly = $urandom_range(0, 3);
      if (r) begin
        ip = 0; lp = 0;
      end else begin
        if (o_if_rdy) ip = 0;
        if (o_ls_rdy) lp = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
